ucaspian_host_link: RTL
=======================

Name: ucaspian_host_link

Overview:
Host-side counterpart of the uCaspian packet interface. Encodes host commands (input fire, run steps, clear activity, metric read) into the byte stream that the core's RX port consumes. Decodes the core's TX byte stream (output fires, time reports, acks, metric values) into single-cycle event words. Sits on the FPGA host bridge or bench side of the 8-bit valid/ready byte link, and tracks outstanding un-acked commands.

Parameters:
MAX_OUTSTANDING, 4, max commands in flight awaiting ACK (1..15)
RX_TIMEOUT, 1024, idle cycles allowed between bytes of one RX packet before abort (>=2)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
cmd_op  in  2  0=FIRE, 1=STEP, 2=CLEAR_ACT, 3=METRIC
cmd_arg0  in  8  FIRE addr / STEP count / METRIC addr
cmd_arg1  in  8  FIRE value (ignored otherwise)
cmd_vld  in  1  command valid
cmd_rdy  out  1  command accepted when cmd_vld&&cmd_rdy
tx_data  out  8  byte toward core RX
tx_vld  out  1  byte valid
tx_rdy  in  1  core ready
rx_data  in  8  byte from core TX
rx_vld  in  1  byte valid
rx_rdy  out  1  link ready
evt_type  out  2  0=FIRE_OUT, 1=TIME, 2=ACK, 3=METRIC
evt_addr  out  8  fire / metric address
evt_value  out  8  metric value
evt_time  out  32  time word
evt_vld  out  1  event valid
evt_rdy  in  1  event consumed
outstanding  out  4  un-acked command count
err  out  3  sticky: [0] unknown opcode, [1] RX timeout, [2] spurious ACK
err_clr  in  1  clears err (takes priority over same-cycle set)

Behaviour:
- Reset (reset low, async): all outputs 0, except rx_rdy=1 and cmd_rdy=1. TX FSM goes to IDLE, RX FSM to OPC, counters cleared. A packet in flight is abandoned with no resume.
- TX packet format (opcode byte first): FIRE = 0x01,addr,value; STEP = 0x02,count; CLEAR_ACT = 0x03; METRIC = 0x04,addr.
- TX FSM states:
  - IDLE: cmd_rdy = (outstanding < MAX_OUTSTANDING). On accept, latch the packet and go to SEND.
  - SEND: tx_vld=1 starting the cycle after accept. Each byte advances on tx_vld&&tx_rdy; tx_data is held stable while stalled. After the last byte transfers, return to IDLE.
  - cmd_rdy=0 in SEND, so there is one idle cycle minimum between packets.
- RX packet format: 0x80,addr = FIRE_OUT; 0x81,t[31:24],t[23:16],t[15:8],t[7:0] = TIME (MSB first); 0x82 = ACK; 0x83,addr,value = METRIC.
- RX FSM states: OPC -> BODY (byte counter) -> EVT.
  - OPC: unknown opcode sets err[0], drops the byte, stays in OPC.
  - 1-byte packets (ACK) go directly from OPC to EVT.
  - EVT: evt_vld=1, fields stable until evt_rdy; then return to OPC. rx_rdy=0 in EVT, otherwise 1. Event latency is 1 cycle after the final byte.
  - Unused evt fields are 0.
- Timeout: an idle counter runs in BODY only and resets on each accepted byte. Reaching RX_TIMEOUT sets err[1], discards the partial packet, and returns to OPC.
- outstanding:
  - +1 on command accept, -1 when an ACK event is presented.
  - Simultaneous accept and ACK leaves it unchanged.
  - ACK at 0 keeps 0 and sets err[2]; the ACK event is still emitted.
- Every command type expects exactly one ACK.

Decomposition:
- Package ucaspian_host_pkg holds:
  - cmd_op_t and evt_type_t enums
  - TX opcode constants 0x01-0x04 and RX opcode constants 0x80-0x83
  - a function giving packet length per opcode
- Sub-module ucaspian_host_rx_decoder contains the RX FSM, timeout counter and event register. The top keeps the TX encoder and the outstanding counter.

Test Plan:
- FIRE addr=0x12 val=0x7F, tx_rdy=1 -> tx bytes 01,12,7F on 3 consecutive cycles starting 1 cycle after accept; outstanding=1.
- tx_rdy low 3 cycles while byte 2 (0x12) is presented -> tx_data holds 0x12 and tx_vld stays 1; stream completes unchanged.
- rx 81,00,00,01,2C -> one event, evt_type=TIME, evt_time=0x0000012C. With evt_rdy low 5 cycles, rx_rdy=0 and the event is held.
- MAX_OUTSTANDING=2: STEP 10, CLEAR_ACT -> cmd_rdy=0 on the third command. rx 82 -> ACK event, outstanding=1, cmd_rdy=1. A further ACK at outstanding=0 -> err[2]=1.
- rx 55 -> err[0]=1, no event. Then rx 83,07 and RX_TIMEOUT idle cycles -> err[1]=1, no event. Then rx 83,07,AB -> METRIC addr=07 value=AB. err_clr -> err=0.
- reset low mid-FIRE (after byte 1) -> tx_vld=0 immediately (async), outstanding=0. After release, a new STEP 5 sends 02,05 cleanly.

Source files
------------

// File: rtl/ucaspian_host_pkg.sv
// Shared types, opcode constants and packet-length helpers for the
// uCaspian host link (TX command encoder and RX event decoder).
package ucaspian_host_pkg;

   typedef enum logic [1:0] {
      CMD_FIRE      = 2'd0,
      CMD_STEP      = 2'd1,
      CMD_CLEAR_ACT = 2'd2,
      CMD_METRIC    = 2'd3
   } cmd_op_t;

   typedef enum logic [1:0] {
      EVT_FIRE_OUT = 2'd0,
      EVT_TIME     = 2'd1,
      EVT_ACK      = 2'd2,
      EVT_METRIC   = 2'd3
   } evt_type_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_OPC  = 2'd0,
      RX_BODY = 2'd1,
      RX_EVT  = 2'd2
   } rx_state_t;

   // Opcode bytes sent toward the core
   localparam logic [7:0] TX_OPC_FIRE      = 8'h01;
   localparam logic [7:0] TX_OPC_STEP      = 8'h02;
   localparam logic [7:0] TX_OPC_CLEAR_ACT = 8'h03;
   localparam logic [7:0] TX_OPC_METRIC    = 8'h04;

   // Opcode bytes received from the core
   localparam logic [7:0] RX_OPC_FIRE_OUT = 8'h80;
   localparam logic [7:0] RX_OPC_TIME     = 8'h81;
   localparam logic [7:0] RX_OPC_ACK      = 8'h82;
   localparam logic [7:0] RX_OPC_METRIC   = 8'h83;

   // Total TX packet length in bytes, opcode byte included
   function automatic logic [1:0] tx_pkt_len(input cmd_op_t op);
      logic [1:0] len;
      case (op)
         CMD_FIRE:      len = 2'd3;
         CMD_STEP:      len = 2'd2;
         CMD_CLEAR_ACT: len = 2'd1;
         CMD_METRIC:    len = 2'd2;
         default:       len = 2'd1;
      endcase
      return len;
   endfunction

   // Opcode byte leading each TX packet
   function automatic logic [7:0] tx_opcode(input cmd_op_t op);
      logic [7:0] opc;
      case (op)
         CMD_FIRE:      opc = TX_OPC_FIRE;
         CMD_STEP:      opc = TX_OPC_STEP;
         CMD_CLEAR_ACT: opc = TX_OPC_CLEAR_ACT;
         CMD_METRIC:    opc = TX_OPC_METRIC;
         default:       opc = TX_OPC_CLEAR_ACT;
      endcase
      return opc;
   endfunction

   // Total RX packet length in bytes; 0 flags an unknown opcode
   function automatic logic [2:0] rx_pkt_len(input logic [7:0] opc);
      logic [2:0] len;
      case (opc)
         RX_OPC_FIRE_OUT: len = 3'd2;
         RX_OPC_TIME:     len = 3'd5;
         RX_OPC_ACK:      len = 3'd1;
         RX_OPC_METRIC:   len = 3'd3;
         default:         len = 3'd0;
      endcase
      return len;
   endfunction

   // Event type reported for a known RX opcode
   function automatic evt_type_t rx_evt_type(input logic [7:0] opc);
      evt_type_t t;
      case (opc)
         RX_OPC_FIRE_OUT: t = EVT_FIRE_OUT;
         RX_OPC_TIME:     t = EVT_TIME;
         RX_OPC_ACK:      t = EVT_ACK;
         RX_OPC_METRIC:   t = EVT_METRIC;
         default:         t = EVT_FIRE_OUT;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/ucaspian_host_link_rx_decoder.sv
// RX side of the host link: parses the core's TX byte stream into
// single event words, with an inter-byte timeout inside a packet.
module ucaspian_host_rx_decoder
   import ucaspian_host_pkg::*;
#(
   parameter int unsigned RX_TIMEOUT = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_vld,
   output logic        o_rx_rdy,
   output logic [1:0]  o_evt_type,
   output logic [7:0]  o_evt_addr,
   output logic [7:0]  o_evt_value,
   output logic [31:0] o_evt_time,
   output logic        o_evt_vld,
   input  logic        i_evt_rdy,
   output logic        o_ack_pulse,
   output logic        o_err_opc,
   output logic        o_err_tmo
);

   localparam int TW = $clog2(RX_TIMEOUT + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(RX_TIMEOUT - 1);

   rx_state_t     r_state;
   rx_state_t     w_state_nxt;
   logic [7:0]    r_opc;
   logic [2:0]    r_cnt;
   logic [23:0]   r_buf;
   logic [TW-1:0] r_idle;
   evt_type_t     r_evt_type;
   logic [7:0]    r_evt_addr;
   logic [7:0]    r_evt_value;
   logic [31:0]   r_evt_time;

   logic [2:0]    w_opc_len;
   logic          w_idle_expired;
   logic          w_load_evt;
   logic [7:0]    w_evt_opc;
   logic [31:0]   w_pkt;

   assign w_opc_len      = rx_pkt_len(i_rx_data);
   assign w_idle_expired = (r_idle == IDLE_LAST);
   assign w_pkt          = {r_buf, i_rx_data};

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RX_OPC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RX_OPC: begin
            if (i_rx_vld && (w_opc_len == 3'd1)) begin
               w_state_nxt = RX_EVT;
            end else if (i_rx_vld && (w_opc_len != 3'd0)) begin
               w_state_nxt = RX_BODY;
            end else begin
               w_state_nxt = RX_OPC;
            end
         end
         RX_BODY: begin
            if (i_rx_vld) begin
               w_state_nxt = (r_cnt == 3'd1) ? RX_EVT : RX_BODY;
            end else if (w_idle_expired) begin
               w_state_nxt = RX_OPC;
            end else begin
               w_state_nxt = RX_BODY;
            end
         end
         RX_EVT: begin
            if (i_evt_rdy) begin
               w_state_nxt = RX_OPC;
            end else begin
               w_state_nxt = RX_EVT;
            end
         end
         default: w_state_nxt = RX_OPC;
      endcase
   end

   // Output and strobe decode from the current state
   always_comb begin
      o_rx_rdy    = (r_state != RX_EVT);
      o_evt_vld   = (r_state == RX_EVT);
      o_err_opc   = 1'b0;
      o_err_tmo   = 1'b0;
      w_load_evt  = 1'b0;
      w_evt_opc   = r_opc;
      case (r_state)
         RX_OPC: begin
            w_evt_opc  = i_rx_data;
            o_err_opc  = i_rx_vld && (w_opc_len == 3'd0);
            w_load_evt = i_rx_vld && (w_opc_len == 3'd1);
         end
         RX_BODY: begin
            w_evt_opc  = r_opc;
            o_err_tmo  = !i_rx_vld && w_idle_expired;
            w_load_evt = i_rx_vld && (r_cnt == 3'd1);
         end
         RX_EVT: begin
            w_evt_opc = r_opc;
         end
         default: begin
            w_evt_opc = r_opc;
         end
      endcase
      o_ack_pulse = w_load_evt && (w_evt_opc == RX_OPC_ACK);
   end

   // Packet body collection and inter-byte idle counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_opc  <= 8'h00;
         r_cnt  <= 3'd0;
         r_buf  <= 24'h000000;
         r_idle <= '0;
      end else if ((r_state == RX_OPC) && i_rx_vld && (w_opc_len > 3'd1)) begin
         r_opc  <= i_rx_data;
         r_cnt  <= w_opc_len - 3'd1;
         r_buf  <= 24'h000000;
         r_idle <= '0;
      end else if ((r_state == RX_BODY) && i_rx_vld) begin
         r_buf  <= w_pkt[23:0];
         r_cnt  <= r_cnt - 3'd1;
         r_idle <= '0;
      end else if (r_state == RX_BODY) begin
         r_idle <= r_idle + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         r_idle <= r_idle;
      end
   end

   // Event register: loaded on the final byte, zeroed once consumed
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_evt_type  <= EVT_FIRE_OUT;
         r_evt_addr  <= 8'h00;
         r_evt_value <= 8'h00;
         r_evt_time  <= 32'h0000_0000;
      end else if (w_load_evt) begin
         r_evt_type  <= rx_evt_type(w_evt_opc);
         r_evt_addr  <= 8'h00;
         r_evt_value <= 8'h00;
         r_evt_time  <= 32'h0000_0000;
         case (w_evt_opc)
            RX_OPC_FIRE_OUT: r_evt_addr <= w_pkt[7:0];
            RX_OPC_TIME:     r_evt_time <= w_pkt;
            RX_OPC_METRIC: begin
               r_evt_addr  <= w_pkt[15:8];
               r_evt_value <= w_pkt[7:0];
            end
            default: r_evt_time <= 32'h0000_0000;
         endcase
      end else if ((r_state == RX_EVT) && i_evt_rdy) begin
         r_evt_type  <= EVT_FIRE_OUT;
         r_evt_addr  <= 8'h00;
         r_evt_value <= 8'h00;
         r_evt_time  <= 32'h0000_0000;
      end else begin
         r_evt_type  <= r_evt_type;
      end
   end

   assign o_evt_type  = r_evt_type;
   assign o_evt_addr  = r_evt_addr;
   assign o_evt_value = r_evt_value;
   assign o_evt_time  = r_evt_time;

endmodule

// File: rtl/ucaspian_host_link.sv
// Host-side uCaspian byte link: encodes host commands into the core's RX
// byte stream, decodes the core's TX stream into events, and tracks how
// many commands are still waiting for their ACK.
module ucaspian_host_link
   import ucaspian_host_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned RX_TIMEOUT      = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_cmd_op,
   input  logic [7:0]  i_cmd_arg0,
   input  logic [7:0]  i_cmd_arg1,
   input  logic        i_cmd_vld,
   output logic        o_cmd_rdy,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_vld,
   input  logic        i_tx_rdy,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_vld,
   output logic        o_rx_rdy,
   output logic [1:0]  o_evt_type,
   output logic [7:0]  o_evt_addr,
   output logic [7:0]  o_evt_value,
   output logic [31:0] o_evt_time,
   output logic        o_evt_vld,
   input  logic        i_evt_rdy,
   output logic [3:0]  o_outstanding,
   output logic [2:0]  o_err,
   input  logic        i_err_clr
);

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   tx_state_t  r_tx_state;
   tx_state_t  w_tx_state_nxt;
   logic [7:0] r_tx_data;
   logic [7:0] r_b1;
   logic [7:0] r_b2;
   logic [1:0] r_len;
   logic [1:0] r_idx;
   logic [3:0] r_outstanding;
   logic [2:0] r_err;

   logic       w_cmd_rdy;
   logic       w_tx_vld;
   logic       w_accept;
   logic       w_xfer;
   logic       w_last;
   logic       w_ack;
   logic       w_err_opc;
   logic       w_err_tmo;
   logic       w_err_spur;
   cmd_op_t    w_op;

   assign w_op     = cmd_op_t'(i_cmd_op);
   assign w_accept = i_cmd_vld && w_cmd_rdy;
   assign w_xfer   = w_tx_vld && i_tx_rdy;
   assign w_last   = (r_idx == (r_len - 2'd1));

   // TX state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_state <= TX_IDLE;
      end else begin
         r_tx_state <= w_tx_state_nxt;
      end
   end

   // TX next-state logic
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      case (r_tx_state)
         TX_IDLE: begin
            if (w_accept) begin
               w_tx_state_nxt = TX_SEND;
            end else begin
               w_tx_state_nxt = TX_IDLE;
            end
         end
         TX_SEND: begin
            if (w_xfer && w_last) begin
               w_tx_state_nxt = TX_IDLE;
            end else begin
               w_tx_state_nxt = TX_SEND;
            end
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
   end

   // TX handshake outputs from the current state
   always_comb begin
      w_cmd_rdy = 1'b0;
      w_tx_vld  = 1'b0;
      case (r_tx_state)
         TX_IDLE: w_cmd_rdy = (r_outstanding < MAX_OUT);
         TX_SEND: w_tx_vld  = 1'b1;
         default: w_tx_vld  = 1'b0;
      endcase
   end

   // Packet latch and byte sequencing; tx_data only moves on a transfer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_data <= 8'h00;
         r_b1      <= 8'h00;
         r_b2      <= 8'h00;
         r_len     <= 2'd0;
         r_idx     <= 2'd0;
      end else if (w_accept) begin
         r_tx_data <= tx_opcode(w_op);
         r_b1      <= i_cmd_arg0;
         r_b2      <= i_cmd_arg1;
         r_len     <= tx_pkt_len(w_op);
         r_idx     <= 2'd0;
      end else if (w_xfer && w_last) begin
         r_tx_data <= 8'h00;
         r_idx     <= 2'd0;
      end else if (w_xfer) begin
         r_tx_data <= (r_idx == 2'd0) ? r_b1 : r_b2;
         r_idx     <= r_idx + 2'd1;
      end else begin
         r_tx_data <= r_tx_data;
      end
   end

   ucaspian_host_rx_decoder #(
      .RX_TIMEOUT (RX_TIMEOUT)
   ) u_rx_decoder (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rx_data   (i_rx_data),
      .i_rx_vld    (i_rx_vld),
      .o_rx_rdy    (o_rx_rdy),
      .o_evt_type  (o_evt_type),
      .o_evt_addr  (o_evt_addr),
      .o_evt_value (o_evt_value),
      .o_evt_time  (o_evt_time),
      .o_evt_vld   (o_evt_vld),
      .i_evt_rdy   (i_evt_rdy),
      .o_ack_pulse (w_ack),
      .o_err_opc   (w_err_opc),
      .o_err_tmo   (w_err_tmo)
   );

   // An ACK with nothing outstanding (and no same-cycle accept) is spurious
   assign w_err_spur = w_ack && !w_accept && (r_outstanding == 4'd0);

   // Outstanding-command counter: +1 per accept, -1 per ACK event, floor at 0
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_outstanding <= 4'd0;
      end else begin
         case ({w_accept, w_ack})
            2'b10:   r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= (r_outstanding == 4'd0) ? 4'd0 : (r_outstanding - 4'd1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Sticky error flags; a clear wins over a same-cycle set
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err <= 3'b000;
      end else if (i_err_clr) begin
         r_err <= 3'b000;
      end else begin
         r_err <= r_err | {w_err_spur, w_err_tmo, w_err_opc};
      end
   end

   assign o_cmd_rdy     = w_cmd_rdy;
   assign o_tx_vld      = w_tx_vld;
   assign o_tx_data     = r_tx_data;
   assign o_outstanding = r_outstanding;
   assign o_err         = r_err;

endmodule
